rng_harvester: RTL and testbench
================================

RNG_HARVESTER -- requirements
Module: rng_harvester

Interface
REQ-001 SHALL have parameter DECIM, default 4: count of raw rnd bytes XOR-folded into one conditioned byte (legal range 1..16).
REQ-002 SHALL have parameter WARMUP, default 16: raw samples discarded after reset (legal range 1..255).
REQ-003 SHALL have parameter RCT_LIMIT, default 8: identical consecutive conditioned bytes that trip the health test (legal range 2..255).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port rnd, input, 8: raw entropy byte from the ring-oscillator TRNG stage, sampled every clk.
REQ-007 SHALL have port rnd_ready, input, 1: consumer accepts rnd_word this cycle.
REQ-008 SHALL have port rnd_valid, output, 1: rnd_word holds an unread word.
REQ-009 SHALL have port rnd_word, output, 16: FIFO head word.
REQ-010 SHALL have port health_fail, output, 1: sticky repetition-count failure flag.
REQ-011 SHALL have port dropped_cnt, output, 8: count of words lost to FIFO overflow, saturating.

Function
REQ-012 SHALL implement a three-state FSM (WARMUP, RUN, FAIL); reset enters WARMUP.
REQ-013 WARMUP SHALL count WARMUP samples of rnd, discarding them, then enter RUN; the fold counter and pack state SHALL be zero on entry to RUN.
REQ-014 In RUN, fold counter SHALL cycle 0..DECIM-1; acc <= rnd when counter is 0, else acc ^ rnd; at counter DECIM-1 the conditioned byte is (acc ^ rnd), or rnd when DECIM=1.
REQ-015 The RCT SHALL compare each conditioned byte with the previous one: equal -> rep_cnt+1, else rep_cnt=1; the first byte after entering RUN sets rep_cnt=1.
REQ-016 When rep_cnt would reach RCT_LIMIT, the FSM SHALL enter FAIL on that edge, set health_fail=1, discard that byte, and flush the FIFO.
REQ-017 FAIL SHALL be exited only by rst; in FAIL, rnd_valid=0 and no pushes occur.
REQ-018 Conditioned bytes SHALL be paired: first byte -> rnd_word[15:8], second -> [7:0]; the word is pushed on the edge the second byte is formed.
REQ-019 The FIFO SHALL hold 4 words; rnd_valid = FIFO non-empty; rnd_word = head, stable while rnd_valid=1 and rnd_ready=0.
REQ-020 A pop SHALL occur on an edge with rnd_valid=1 and rnd_ready=1; rnd_ready with rnd_valid=0 has no effect.
REQ-021 A push SHALL be accepted if FIFO not full, or if full and a pop occurs on the same edge; otherwise the word is dropped and dropped_cnt increments, saturating at 255.
REQ-022 Latency: with FIFO empty, rnd_valid SHALL rise on the edge after the sample that completes a word; no combinational path from rnd to outputs.

Reset
REQ-023 On rst=1 at an edge: state=WARMUP, FIFO empty, rnd_valid=0, rnd_word=0, health_fail=0, dropped_cnt=0, rep_cnt/acc/counters/pack state=0.
REQ-024 rst SHALL take precedence over every other event, including mid-word, mid-fold, in FAIL, and during a simultaneous push/pop.

Verification
REQ-025 Reset: assert rst 2 cycles with arbitrary rnd -> all outputs 0; first rnd_valid no earlier than WARMUP+2*DECIM samples after rst release.
REQ-026 Constant rnd=8'hA5, DECIM=4, rnd_ready=0 -> conditioned bytes all 8'h00; 3 words 16'h0000 pushed; health_fail=1 at the 8th conditioned byte; rnd_valid=0 thereafter until rst.
REQ-027 DECIM=1, rnd repeating 8'h12,8'h34,8'h56,8'h78 from RUN entry, rnd_ready=1 -> rnd_word sequence 16'h1234,16'h5678,... with no drops and health_fail=0.
REQ-028 Same pattern, rnd_ready=0 for 8 words -> 4 words held, dropped_cnt=4; then rnd_ready=1 drains 16'h1234,16'h5678,16'h1234,16'h5678 in order.
REQ-029 FIFO full, rnd_ready=1 on the edge a new word completes -> pop and push both occur, occupancy stays 4, dropped_cnt unchanged.
REQ-030 rst pulsed mid-word with 2 words in FIFO -> next edge rnd_valid=0, dropped_cnt=0, WARMUP restarts; first post-reset word contains no pre-reset bytes.

Source files
------------

// File: rtl/rng_harvester.sv
// rng_harvester
// Conditions raw ring-oscillator TRNG bytes into 16-bit random words.
// After a warm-up period, DECIM raw bytes are XOR-folded into one
// conditioned byte. A repetition-count health test watches the conditioned
// bytes. Pairs of bytes are packed into words and buffered in a 4-deep FIFO.
//
// Ports:
//   clk         - single clock, rising-edge
//   rst         - synchronous active-high reset
//   rnd         - raw entropy byte, sampled every cycle
//   rnd_ready   - consumer accepts rnd_word this cycle
//   rnd_valid   - rnd_word holds an unread word (FIFO non-empty)
//   rnd_word    - FIFO head word
//   health_fail - sticky repetition-count failure flag
//   dropped_cnt - saturating count of words lost to FIFO overflow
module rng_harvester #(
  parameter int DECIM     = 4,
  parameter int WARMUP    = 16,
  parameter int RCT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rnd,
  input  logic        rnd_ready,
  output logic        rnd_valid,
  output logic [15:0] rnd_word,
  output logic        health_fail,
  output logic [7:0]  dropped_cnt
);

  localparam logic [3:0] FOLD_LAST = 4'(DECIM - 1);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);
  localparam logic [7:0] RCT_LIM   = 8'(RCT_LIMIT);

  typedef enum logic [1:0] {
    S_WARMUP,
    S_RUN,
    S_FAIL
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  warm_cnt;
  logic [3:0]  fold_cnt;
  logic [7:0]  acc;
  logic [7:0]  prev_byte;
  logic [7:0]  rep_cnt;
  logic        have_prev;
  logic        half;
  logic [7:0]  hi_byte;

  logic [15:0] mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;

  logic        byte_done;
  logic [7:0]  cond_byte;
  logic [7:0]  rep_next;
  logic        rct_trip;
  logic        word_done;
  logic        pop;
  logic        push_ok;
  logic        drop;

  // Fold and health-test datapath. At fold count 0 the accumulator restarts
  // from rnd, so the same expression also covers DECIM=1.
  always_comb begin
    byte_done = (state == S_RUN) && (fold_cnt == FOLD_LAST);
    cond_byte = (fold_cnt == 4'd0) ? rnd : (acc ^ rnd);
    rep_next  = (have_prev && (cond_byte == prev_byte)) ? (rep_cnt + 8'd1) : 8'd1;
    rct_trip  = byte_done && (rep_next == RCT_LIM);
    word_done = byte_done && !rct_trip && half;
    pop       = rnd_valid && rnd_ready;
    push_ok   = word_done && ((count != 3'd4) || pop);
    drop      = word_done && !push_ok;
  end

  // Next-state logic; FAIL is only left through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_WARMUP: if (warm_cnt == WARM_LAST) state_next = S_RUN;
      S_RUN:    if (rct_trip) state_next = S_FAIL;
      S_FAIL:   state_next = S_FAIL;
      default:  state_next = S_WARMUP;
    endcase
  end

  // Outputs come from registers only; the head is masked while empty.
  always_comb begin
    rnd_valid = (state != S_FAIL) && (count != 3'd0);
    rnd_word  = rnd_valid ? mem[rd_ptr] : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WARMUP;
    end else begin
      state <= state_next;
    end
  end

  // Control and FIFO bookkeeping. A health trip flushes the FIFO and
  // discards the tripping byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt    <= 8'd0;
      fold_cnt    <= 4'd0;
      acc         <= 8'd0;
      prev_byte   <= 8'd0;
      rep_cnt     <= 8'd0;
      have_prev   <= 1'b0;
      half        <= 1'b0;
      hi_byte     <= 8'd0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      count       <= 3'd0;
      health_fail <= 1'b0;
      dropped_cnt <= 8'd0;
    end else begin
      if (state == S_WARMUP) begin
        warm_cnt <= warm_cnt + 8'd1;
      end

      if (state == S_RUN) begin
        fold_cnt <= byte_done ? 4'd0 : (fold_cnt + 4'd1);
        acc      <= cond_byte;
      end

      if (byte_done) begin
        prev_byte <= cond_byte;
        rep_cnt   <= rep_next;
        have_prev <= 1'b1;
        if (!rct_trip) begin
          if (!half) begin
            hi_byte <= cond_byte;
          end
          half <= ~half;
        end
      end

      if (rct_trip) begin
        health_fail <= 1'b1;
        rd_ptr      <= 2'd0;
        wr_ptr      <= 2'd0;
        count       <= 3'd0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
        count <= count + {2'b00, push_ok} - {2'b00, pop};
      end

      if (drop && (dropped_cnt != 8'hFF)) begin
        dropped_cnt <= dropped_cnt + 8'd1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok && !rct_trip) begin
      mem[wr_ptr] <= {hi_byte, cond_byte};
    end
  end

endmodule

// File: tb/tb_rng_harvester.sv
// tb_rng_harvester
// Directed bench for rng_harvester. Two instances share the clock:
// dut_a uses the default parameters (DECIM=4), dut_b uses DECIM=1.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rng_harvester;

  logic        clk = 1'b0;

  logic        rst_a;
  logic [7:0]  rnd_a;
  logic        ready_a;
  logic        valid_a;
  logic [15:0] word_a;
  logic        fail_a;
  logic [7:0]  dropped_a;

  logic        rst_b;
  logic [7:0]  rnd_b;
  logic        ready_b;
  logic        valid_b;
  logic [15:0] word_b;
  logic        fail_b;
  logic [7:0]  dropped_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] WA = 16'h1234;
  localparam logic [15:0] WB = 16'h5678;

  logic [7:0] pattern [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  always #5 clk = ~clk;

  rng_harvester #(.DECIM(4), .WARMUP(16), .RCT_LIMIT(8)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .rnd         (rnd_a),
    .rnd_ready   (ready_a),
    .rnd_valid   (valid_a),
    .rnd_word    (word_a),
    .health_fail (fail_a),
    .dropped_cnt (dropped_a)
  );

  rng_harvester #(.DECIM(1), .WARMUP(16), .RCT_LIMIT(8)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .rnd         (rnd_b),
    .rnd_ready   (ready_b),
    .rnd_valid   (valid_b),
    .rnd_word    (word_b),
    .health_fail (fail_b),
    .dropped_cnt (dropped_b)
  );

  // Drive one sample into the selected instance and advance one cycle.
  task automatic applyStimulus(input int which, input logic [7:0] b, input logic ready);
    if (which == 0) begin
      rnd_a   = b;
      ready_a = ready;
    end else begin
      rnd_b   = b;
      ready_b = ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_a = 1'b1; rnd_a = 8'h00; ready_a = 1'b0;
    rst_b = 1'b1; rnd_b = 8'h00; ready_b = 1'b0;

    // Reset held two cycles with arbitrary data.
    applyStimulus(0, 8'h3C, 1'b1);
    applyStimulus(0, 8'hC3, 1'b1);
    $display("[TB] reset state");
    checkOutput("rst_valid",   {15'd0, valid_a}, 16'd0);
    checkOutput("rst_word",    word_a,           16'd0);
    checkOutput("rst_health",  {15'd0, fail_a},  16'd0);
    checkOutput("rst_dropped", {8'd0, dropped_a}, 16'd0);

    // Constant A5 with DECIM=4: every conditioned byte is 00.
    rst_a = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      applyStimulus(0, 8'hA5, 1'b0);
      checkOutput($sformatf("early_valid_%0d", n), {15'd0, valid_a}, 16'd0);
    end
    applyStimulus(0, 8'hA5, 1'b0);
    checkOutput("first_valid", {15'd0, valid_a}, 16'd1);
    checkOutput("first_word",  word_a,           16'h0000);
    for (int n = 25; n <= 47; n++) applyStimulus(0, 8'hA5, 1'b0);
    checkOutput("pre_trip_health", {15'd0, fail_a},  16'd0);
    checkOutput("pre_trip_valid",  {15'd0, valid_a}, 16'd1);
    applyStimulus(0, 8'hA5, 1'b0);
    checkOutput("trip_health", {15'd0, fail_a},  16'd1);
    checkOutput("trip_valid",  {15'd0, valid_a}, 16'd0);
    checkOutput("trip_word",   word_a,           16'h0000);
    for (int n = 0; n < 8; n++) begin
      applyStimulus(0, 8'(n * 37), 1'b1);
      checkOutput($sformatf("fail_valid_%0d", n), {15'd0, valid_a}, 16'd0);
    end
    checkOutput("fail_sticky",  {15'd0, fail_a},   16'd1);
    checkOutput("fail_dropped", {8'd0, dropped_a}, 16'd0);
    rst_a = 1'b1;
    applyStimulus(0, 8'hA5, 1'b0);
    checkOutput("fail_rst_health", {15'd0, fail_a}, 16'd0);

    // DECIM=1, pattern from RUN entry, consumer always ready.
    $display("[TB] DECIM=1 streaming");
    applyStimulus(1, 8'h00, 1'b1);
    applyStimulus(1, 8'h00, 1'b1);
    rst_b = 1'b0;
    for (int n = 0; n < 16; n++) applyStimulus(1, 8'hEE, 1'b1);
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1, pattern[n % 4], 1'b1);
      if (n % 2 == 1) begin
        checkOutput($sformatf("stream_valid_%0d", n), {15'd0, valid_b}, 16'd1);
        checkOutput($sformatf("stream_word_%0d", n), word_b, (n % 4 == 1) ? WA : WB);
      end
    end
    checkOutput("stream_dropped", {8'd0, dropped_b}, 16'd0);
    checkOutput("stream_health",  {15'd0, fail_b},   16'd0);

    // Overflow: 8 words with consumer stalled, then drain.
    $display("[TB] overflow and drain");
    rst_b = 1'b1;
    applyStimulus(1, 8'h00, 1'b0);
    rst_b = 1'b0;
    for (int n = 0; n < 16; n++) applyStimulus(1, 8'h00, 1'b0);
    for (int n = 0; n < 16; n++) applyStimulus(1, pattern[n % 4], 1'b0);
    checkOutput("ovf_dropped", {8'd0, dropped_b}, 16'd4);
    checkOutput("ovf_valid",   {15'd0, valid_b},  16'd1);
    checkOutput("drain_head0", word_b, WA);
    applyStimulus(1, 8'h12, 1'b1);
    checkOutput("drain_head1", word_b, WB);
    applyStimulus(1, 8'h34, 1'b1);
    checkOutput("drain_head2", word_b, WA);
    applyStimulus(1, 8'h56, 1'b1);
    checkOutput("drain_head3", word_b, WB);
    checkOutput("drain_dropped", {8'd0, dropped_b}, 16'd4);

    // Refill to full, then push and pop on the same edge.
    $display("[TB] simultaneous push/pop when full");
    applyStimulus(1, 8'h78, 1'b0);
    applyStimulus(1, 8'h12, 1'b0);
    applyStimulus(1, 8'h34, 1'b0);
    applyStimulus(1, 8'h56, 1'b0);
    applyStimulus(1, 8'h78, 1'b1);
    checkOutput("pp_dropped", {8'd0, dropped_b}, 16'd4);
    checkOutput("pp_head",    word_b,            WA);
    applyStimulus(1, 8'h12, 1'b0);
    applyStimulus(1, 8'h34, 1'b0);
    checkOutput("pp_still_full", {8'd0, dropped_b}, 16'd5);
    checkOutput("pp_head_held",  word_b,            WA);

    // Bring occupancy to 2 words mid-word, then reset.
    $display("[TB] reset mid-word");
    applyStimulus(1, 8'h12, 1'b1);
    applyStimulus(1, 8'h34, 1'b1);
    applyStimulus(1, 8'h56, 1'b1);
    checkOutput("mid_head", word_b, WB);
    rst_b = 1'b1;
    applyStimulus(1, 8'h78, 1'b1);
    checkOutput("mid_rst_valid",   {15'd0, valid_b},  16'd0);
    checkOutput("mid_rst_dropped", {8'd0, dropped_b}, 16'd0);
    checkOutput("mid_rst_word",    word_b,            16'd0);
    rst_b = 1'b0;
    for (int n = 0; n < 16; n++) applyStimulus(1, 8'h00, 1'b0);
    applyStimulus(1, 8'h9A, 1'b0);
    checkOutput("post_rst_half_valid", {15'd0, valid_b}, 16'd0);
    applyStimulus(1, 8'hBC, 1'b0);
    checkOutput("post_rst_valid", {15'd0, valid_b}, 16'd1);
    checkOutput("post_rst_word",  word_b,           16'h9ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
